hex_rotate_ctrl: RTL and testbench



---
 rtl/hex_lab_pkg.sv | 14 +
 rtl/hex_rotate_ctrl_if.sv | 26 ++
 rtl/tick_prescaler.sv | 36 +++
 rtl/hex_rotate_ctrl.sv | 109 ++++++++++
 tb/tb_hex_rotate_ctrl.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/hex_lab_pkg.sv
// rtl/hex_lab_pkg.sv - shared widths and state type for the HEX rotation lab blocks
package hex_lab_pkg;

  localparam int SEL_W      = 2;
  localparam int CHAR_W     = 2;
  localparam int NUM_DIGITS = 4;
  localparam int PRESET_W   = NUM_DIGITS * CHAR_W;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } rot_state_t;

endpackage

// File: rtl/hex_rotate_ctrl_if.sv
// rtl/hex_rotate_ctrl_if.sv - control/status bundle between switches/keys and the rotation controller
interface hex_rotate_ctrl_if;
  import hex_lab_pkg::*;

  logic [PRESET_W-1:0] preset_in;
  logic                load;
  logic                run;
  logic                dir;
  logic                step;
  logic [SEL_W-1:0]    sel;
  logic [PRESET_W-1:0] preset_q;
  logic                tick;
  logic                wrap;
  logic                busy;

  modport master (
    output preset_in, load, run, dir, step,
    input  sel, preset_q, tick, wrap, busy
  );

  modport slave (
    input  preset_in, load, run, dir, step,
    output sel, preset_q, tick, wrap, busy
  );

endinterface

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - clearable, enabled modulo-DIV counter with terminal-count pulse
module tick_prescaler #(
  parameter int DIV   = 4,
  parameter int CNT_W = $clog2(DIV)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             at_max;

  assign at_max = (cnt_q == CNT_W'(DIV - 1));
  // clear wins over enable so a terminal count is never reported in a clearing cycle
  assign tc     = en & ~clr & at_max;

  // next count: clear, wrap at terminal count, or increment while enabled
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = at_max ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // counter register
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/hex_rotate_ctrl.sv
// rtl/hex_rotate_ctrl.sv - timed/steppable rotation select and preset latch for the HEX rotator
module hex_rotate_ctrl
  import hex_lab_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int CNT_W    = $clog2(TICK_DIV)
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  hex_rotate_ctrl_if.slave  bus
);

  rot_state_t          state_q, state_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [PRESET_W-1:0] preset_q, preset_d;
  logic                tick_q, tick_d;
  logic                wrap_q, wrap_d;
  logic                step_dly_q, step_dly_d;
  logic                busy;

  logic run_en;
  logic run_adv;
  logic step_adv;
  logic adv;
  logic wrap_hit;

  // the prescaler only runs in RUN with run still high and no load; otherwise it sits at 0
  assign run_en   = (state_q == RUN) & bus.run & ~bus.load;
  assign step_adv = (state_q == IDLE) & bus.step & ~step_dly_q & ~bus.load;
  assign adv      = run_adv | step_adv;
  assign wrap_hit = bus.dir ? (sel_q == '0) : (sel_q == SEL_W'(NUM_DIGITS - 1));

  tick_prescaler #(
    .DIV   (TICK_DIV),
    .CNT_W (CNT_W)
  ) u_prescaler (
    .clk (CLOCK_50),
    .rst (reset),
    .clr (~run_en),
    .en  (run_en),
    .tc  (run_adv)
  );

  // state register
  always_ff @(posedge CLOCK_50) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // next state: load forces IDLE, run level selects RUN/IDLE
  always_comb begin
    state_d = state_q;
    if (bus.load) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (bus.run)  state_d = RUN;
        RUN:     if (!bus.run) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // state-decoded outputs
  always_comb begin
    busy = (state_q == RUN);
  end

  // datapath next values: load beats any advance and never pulses tick/wrap
  always_comb begin
    sel_d      = sel_q;
    preset_d   = preset_q;
    tick_d     = 1'b0;
    wrap_d     = 1'b0;
    step_dly_d = bus.step;
    if (bus.load) begin
      sel_d    = '0;
      preset_d = bus.preset_in;
    end else if (adv) begin
      sel_d  = bus.dir ? sel_q - SEL_W'(1) : sel_q + SEL_W'(1);
      tick_d = 1'b1;
      wrap_d = wrap_hit;
    end
  end

  // datapath registers
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sel_q      <= '0;
      preset_q   <= '0;
      tick_q     <= 1'b0;
      wrap_q     <= 1'b0;
      step_dly_q <= 1'b0;
    end else begin
      sel_q      <= sel_d;
      preset_q   <= preset_d;
      tick_q     <= tick_d;
      wrap_q     <= wrap_d;
      step_dly_q <= step_dly_d;
    end
  end

  assign bus.sel      = sel_q;
  assign bus.preset_q = preset_q;
  assign bus.tick     = tick_q;
  assign bus.wrap     = wrap_q;
  assign bus.busy     = busy;

endmodule

// File: tb/tb_hex_rotate_ctrl.sv
// tb/tb_hex_rotate_ctrl.sv - directed scoreboard bench for hex_rotate_ctrl
module tb_hex_rotate_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   c;

  typedef struct {
    int         cyc;
    logic [1:0] sel;
    logic       wrap;
  } exp_t;

  exp_t exp_q[$];

  hex_rotate_ctrl_if bus ();

  hex_rotate_ctrl #(.TICK_DIV(4)) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .bus      (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push(input int at, input logic [1:0] s, input logic w);
    exp_t e;
    e.cyc  = at;
    e.sel  = s;
    e.wrap = w;
    exp_q.push_back(e);
  endtask

  // every tick must match the next scoreboard entry in cycle, sel and wrap
  always @(negedge clk) begin
    if (bus.tick === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("tick_unexpected", 32'(bus.tick), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("tick_cyc", cyc, e.cyc);
        check("tick_sel", 32'(bus.sel), 32'(e.sel));
        check("tick_wrap", 32'(bus.wrap), 32'(e.wrap));
      end
    end else begin
      if (bus.wrap !== 1'b0) check("wrap_without_tick", 32'(bus.wrap), 32'd0);
      if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        void'(exp_q.pop_front());
        check("tick_missed", 32'(bus.tick), 32'd1);
      end
    end
  end

  initial begin
    reset         = 1'b1;
    bus.preset_in = '0;
    bus.load      = 1'b0;
    bus.run       = 1'b0;
    bus.dir       = 1'b0;
    bus.step      = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_sel", 32'(bus.sel), 32'd0);
    check("rst_preset", 32'(bus.preset_q), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_tick", 32'(bus.tick), 32'd0);
    check("rst_wrap", 32'(bus.wrap), 32'd0);

    // load preset
    reset         = 1'b0;
    bus.load      = 1'b1;
    bus.preset_in = 8'b00_01_10_11;
    @(negedge clk);
    check("load_preset", 32'(bus.preset_q), 32'h1B);
    check("load_sel", 32'(bus.sel), 32'd0);
    bus.load = 1'b0;

    // RUN forward
    c = cyc;
    push(c + 5, 2'd1, 1'b0);
    push(c + 9, 2'd2, 1'b0);
    push(c + 13, 2'd3, 1'b0);
    push(c + 17, 2'd0, 1'b1);
    push(c + 21, 2'd1, 1'b0);
    bus.run = 1'b1;
    @(negedge clk);
    check("run_busy", 32'(bus.busy), 32'd1);
    repeat (20) @(negedge clk);
    bus.run = 1'b0;
    @(negedge clk);
    check("idle_busy", 32'(bus.busy), 32'd0);
    check("fwd_end_sel", 32'(bus.sel), 32'd1);

    // RUN reverse from 0, dir flipped two cycles into second period
    bus.load = 1'b1;
    @(negedge clk);
    check("reload_sel", 32'(bus.sel), 32'd0);
    bus.load = 1'b0;
    bus.dir  = 1'b1;
    bus.run  = 1'b1;
    c = cyc;
    push(c + 5, 2'd3, 1'b1);
    push(c + 9, 2'd0, 1'b1);
    repeat (6) @(negedge clk);
    bus.dir = 1'b0;
    repeat (3) @(negedge clk);
    bus.run = 1'b0;
    @(negedge clk);
    check("rev_end_sel", 32'(bus.sel), 32'd0);

    // step in IDLE: held high then re-pressed gives exactly two advances
    c = cyc;
    bus.step = 1'b1;
    push(c + 1, 2'd1, 1'b0);
    repeat (10) @(negedge clk);
    bus.step = 1'b0;
    repeat (2) @(negedge clk);
    bus.step = 1'b1;
    push(c + 13, 2'd2, 1'b0);
    repeat (3) @(negedge clk);
    bus.step = 1'b0;
    @(negedge clk);
    check("step_sel", 32'(bus.sel), 32'd2);

    // RUN with step pulses ignored, then load mid-period at sel=2
    c = cyc;
    bus.run = 1'b1;
    push(c + 5, 2'd3, 1'b0);
    push(c + 9, 2'd0, 1'b1);
    push(c + 13, 2'd1, 1'b0);
    push(c + 17, 2'd2, 1'b0);
    repeat (2) @(negedge clk);
    bus.step = 1'b1;
    @(negedge clk);
    bus.step = 1'b0;
    repeat (3) @(negedge clk);
    bus.step = 1'b1;
    @(negedge clk);
    bus.step = 1'b0;
    repeat (12) @(negedge clk);
    check("pre_load_sel", 32'(bus.sel), 32'd2);
    bus.load      = 1'b1;
    bus.preset_in = 8'hA5;
    @(negedge clk);
    check("coll_sel", 32'(bus.sel), 32'd0);
    check("coll_preset", 32'(bus.preset_q), 32'hA5);
    check("coll_tick", 32'(bus.tick), 32'd0);
    check("coll_busy", 32'(bus.busy), 32'd0);
    bus.load = 1'b0;
    push(c + 25, 2'd1, 1'b0);
    repeat (2) @(negedge clk);
    bus.preset_in = 8'hFF;
    repeat (2) @(negedge clk);
    check("preset_hold", 32'(bus.preset_q), 32'hA5);
    @(negedge clk);
    check("resume_sel", 32'(bus.sel), 32'd1);
    bus.run = 1'b0;
    @(negedge clk);

    // reset beats simultaneous load
    reset         = 1'b1;
    bus.load      = 1'b1;
    bus.preset_in = 8'h3C;
    @(negedge clk);
    check("rstload_preset", 32'(bus.preset_q), 32'd0);
    check("rstload_sel", 32'(bus.sel), 32'd0);
    check("rstload_busy", 32'(bus.busy), 32'd0);
    reset    = 1'b0;
    bus.load = 1'b0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
